bt_cmd_parser: RTL and testbench

//  Downstream of the Bluetooth UART receiver. Takes the received byte stream
//  (one-cycle strobe per byte) and frames it into fixed-length command packets.

---
 rtl/bt_cmd_parser_pkg.sv | 20 ++
 rtl/bt_timeout.sv | 30 +++
 rtl/bt_cmd_parser.sv | 113 +++++++++++
 tb/tb_bt_cmd_parser.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bt_cmd_parser_pkg.sv
// Shared definitions for the Bluetooth command parser: header byte, FSM states, opcodes.
// Packet length and state set depend on BT_CMD_CHECKSUM_EN.
package bt_cmd_parser_pkg;

    localparam logic [7:0] HDR_DEFAULT  = 8'hA5;

    localparam logic [7:0] OP_LASER_ON  = 8'h01;
    localparam logic [7:0] OP_LASER_OFF = 8'h02;
    localparam logic [7:0] OP_PAN       = 8'h03;
    localparam logic [7:0] OP_TILT      = 8'h04;

`ifdef BT_CMD_CHECKSUM_EN
    localparam int PKT_LEN = 5;
    typedef enum logic [2:0] {S_IDLE, S_OP, S_ARGH, S_ARGL, S_CHK} state_t;
`else
    localparam int PKT_LEN = 4;
    typedef enum logic [1:0] {S_IDLE, S_OP, S_ARGH, S_ARGL} state_t;
`endif

endpackage

// File: rtl/bt_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, pulses expire on the
// last allowed cycle without a clear.
module bt_timeout #(
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = enable && !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bt_cmd_parser.sv
// Frames UART bytes into HDR/OP/ARG_H/ARG_L[/CHK] commands with a valid/ready output
// and a saturating framing-error counter. Checksum byte enabled by BT_CMD_CHECKSUM_EN.
module bt_cmd_parser
    import bt_cmd_parser_pkg::*;
#(
    parameter logic [7:0]  HDR         = HDR_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 500000,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       cmd_op,
    output logic [15:0]      cmd_arg,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             busy,
    output logic [ERR_W-1:0] err_cnt
);

    state_t      state, state_nxt;
    logic [7:0]  op_q, argh_q;
    logic [15:0] arg_new;
    logic        pkt_done, pkt_bad, expire, load, err_inc;

    bt_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (rx_valid),
        .enable(state != S_IDLE),
        .expire(expire)
    );

`ifdef BT_CMD_CHECKSUM_EN
    logic [7:0] argl_q;
    assign arg_new = {argh_q, argl_q};
`else
    assign arg_new = {argh_q, rx_data};
`endif

    always_comb begin
        state_nxt = state;
        pkt_done  = 1'b0;
        pkt_bad   = 1'b0;
        if (expire) begin
            state_nxt = S_IDLE;
        end else if (rx_valid) begin
            case (state)
                S_IDLE: if (rx_data == HDR) state_nxt = S_OP;
                S_OP:   state_nxt = S_ARGH;
                S_ARGH: state_nxt = S_ARGL;
`ifdef BT_CMD_CHECKSUM_EN
                S_ARGL: state_nxt = S_CHK;
                S_CHK: begin
                    state_nxt = S_IDLE;
                    if (rx_data == (op_q ^ argh_q ^ argl_q)) pkt_done = 1'b1;
                    else                                     pkt_bad  = 1'b1;
                end
`else
                S_ARGL: begin
                    state_nxt = S_IDLE;
                    pkt_done  = 1'b1;
                end
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // A finished packet only replaces the output if the slot is free or being drained now
    assign load    = pkt_done && (!cmd_valid || cmd_ready);
    assign err_inc = (pkt_done && !load) || pkt_bad || expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_arg   <= '0;
            err_cnt   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            if (load) begin
                cmd_valid <= 1'b1;
                cmd_op    <= op_q;
                cmd_arg   <= arg_new;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (err_inc && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
    end

    // Payload capture carries no control meaning, so it is left unreset
    always_ff @(posedge clk) begin
        if (rx_valid) begin
            case (state)
                S_OP:   op_q   <= rx_data;
                S_ARGH: argh_q <= rx_data;
`ifdef BT_CMD_CHECKSUM_EN
                S_ARGL: argl_q <= rx_data;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Self-checking bench for bt_cmd_parser: directed scenarios plus random byte traffic
// against a packet-level model. Works with or without BT_CMD_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_bt_cmd_parser;
    import bt_cmd_parser_pkg::*;

    localparam int TC = 40;
    localparam int E5 = (PKT_LEN == 5) ? 3 : 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        cmd_valid;
    logic        busy;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bt_cmd_parser #(
        .HDR(8'hA5), .TIMEOUT_CYC(TC), .ERR_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .busy(busy), .err_cnt(err_cnt)
    );

    // Packet-level reference: collected bytes, idle gap length, one pending command
    logic        m_busy, m_valid;
    logic [7:0]  m_op;
    logic [15:0] m_arg;
    int          m_err, nb, gap;
    logic [7:0]  pkt [5];

    always @(posedge clk or negedge rst_n) begin
        bit done, bad, acc;
        if (!rst_n) begin
            m_busy = 1'b0; m_valid = 1'b0; m_op = 8'h00; m_arg = 16'h0000;
            m_err = 0; nb = 0; gap = 0;
        end else begin
            acc  = m_valid && cmd_ready;
            done = 1'b0;
            bad  = 1'b0;
            if (!m_busy) begin
                if (rx_valid && rx_data == 8'hA5) begin
                    m_busy = 1'b1; nb = 0; gap = 0;
                end
            end else if (rx_valid) begin
                pkt[nb] = rx_data;
                nb++;
                gap = 0;
                if (nb == PKT_LEN - 1) begin
                    m_busy = 1'b0;
                    if (PKT_LEN == 5 && pkt[3] != (pkt[0] ^ pkt[1] ^ pkt[2])) bad = 1'b1;
                    else done = 1'b1;
                end
            end else begin
                gap++;
                if (gap == TC) begin
                    m_busy = 1'b0;
                    bad = 1'b1;
                end
            end
            if (done && (!m_valid || cmd_ready)) begin
                m_valid = 1'b1; m_op = pkt[0]; m_arg = {pkt[1], pkt[2]};
            end else begin
                if (done) bad = 1'b1;
                if (acc) m_valid = 1'b0;
            end
            if (bad && m_err < 255) m_err++;
        end
    end

    // Hand-computed expectations posted by the stimulus process
    logic        lit_en = 1'b0, lit_v = 1'b0, lit_busy = 1'b0;
    logic [7:0]  lit_op = 8'h00;
    logic [15:0] lit_arg = 16'h0000;
    int          lit_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
        chk("cmd_op",    32'(cmd_op),    32'(m_op));
        chk("cmd_arg",   32'(cmd_arg),   32'(m_arg));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("err_cnt",   32'(err_cnt),   32'(m_err));
        if (lit_en) begin
            chk("pin_valid", 32'(cmd_valid), 32'(lit_v));
            chk("pin_op",    32'(cmd_op),    32'(lit_op));
            chk("pin_arg",   32'(cmd_arg),   32'(lit_arg));
            chk("pin_err",   32'(err_cnt),   32'(lit_err));
            chk("pin_busy",  32'(busy),      32'(lit_busy));
        end
    end

    task automatic pin(input logic v, input logic [7:0] op, input logic [15:0] arg,
                       input int err, input logic b);
        lit_v = v; lit_op = op; lit_arg = arg; lit_err = err; lit_busy = b;
        lit_en = 1'b1;
        @(negedge clk);
        #1 lit_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] op, input logic [15:0] arg);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(arg[15:8]);
        send_byte(arg[7:0]);
        if (PKT_LEN == 5) send_byte(op ^ arg[15:8] ^ arg[7:0]);
    endtask

    task automatic ready_next(input logic r);
        @(posedge clk);
        #1 cmd_ready = r;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        pin(1'b0, 8'h00, 16'h0000, 0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic packet with consumer ready
        send_pkt(OP_LASER_ON, 16'h1234);
        pin(1'b1, 8'h01, 16'h1234, 0, 1'b0);

        // Garbage before header is ignored
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
        send_pkt(OP_LASER_OFF, 16'h0005);
        pin(1'b1, 8'h02, 16'h0005, 0, 1'b0);

        // Timeout mid-packet, then recovery
        send_byte(8'hA5); send_byte(OP_PAN);
        repeat (TC - 5) @(posedge clk);
        #1 pin(1'b0, 8'h02, 16'h0005, 0, 1'b1);
        repeat (8) @(posedge clk);
        #1 pin(1'b0, 8'h02, 16'h0005, 1, 1'b0);
        send_pkt(OP_TILT, 16'h0102);
        pin(1'b1, 8'h04, 16'h0102, 1, 1'b0);

        // Back-pressure: first held, second dropped
        ready_next(1'b0);
        send_pkt(8'h05, 16'h1111);
        send_pkt(8'h06, 16'h2222);
        pin(1'b1, 8'h05, 16'h1111, 2, 1'b0);
        repeat (3) @(posedge clk);
        #1 pin(1'b1, 8'h05, 16'h1111, 2, 1'b0);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;

        // Checksum-dependent packet
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
`ifdef BT_CMD_CHECKSUM_EN
        send_byte(8'h00);
        pin(1'b0, 8'h05, 16'h1111, 3, 1'b0);
`else
        pin(1'b1, 8'h01, 16'h1234, 2, 1'b0);
`endif

        // Async reset mid-packet with a command pending
        ready_next(1'b0);
        send_pkt(8'h07, 16'h0707);
        send_byte(8'hA5); send_byte(8'h08);
        pin(1'b1, 8'h07, 16'h0707, E5, 1'b1);
        #2 rst_n = 1'b0;
        pin(1'b0, 8'h00, 16'h0000, 0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Error counter saturation: one held command, 300 dropped
        send_pkt(8'h20, 16'hBEEF);
        for (int i = 0; i < 300; i++) send_pkt(8'(i), 16'(i * 3));
        pin(1'b1, 8'h20, 16'hBEEF, 255, 1'b0);

        // Random traffic
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                rx_valid = 1'b0;
                repeat (TC + 5) begin
                    cmd_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
            cmd_ready = ($urandom_range(0, 9) < 6);
            rx_valid  = ($urandom_range(0, 9) < 5);
            rx_data   = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
